// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_AR  = 2'd0,
    S_R   = 2'd1,
    S_OUT = 2'd2,
    S_NPC = 2'd3
  } ifu_state_e;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;

  // Instructions are 4-byte aligned; only the two low PC bits matter.
  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return |pc_lo;
  endfunction

endpackage

// File: rtl/ifu_perf.sv
// Fetch performance counters, present only when IFU_PERF_EN is defined.
module ifu_perf
  import ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_evt,
  input  logic        stall_evt,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fetch_evt) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (stall_evt) perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Multi-cycle instruction fetch: one bus read per instruction, then wait for the next PC.
// Optional performance counters are enabled with the IFU_PERF_EN macro.
module inst_fetch
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          BUS_DW   = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [BUS_DW-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       inst,
  output logic [63:0]       inst_pc,
  output logic              inst_fault,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic [63:0]       npc,
  input  logic              npc_valid
`ifdef IFU_PERF_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_stall_cnt
`endif
);

  ifu_state_e  state, next_state;
  logic [63:0] pc, pc_d;
  logic [31:0] inst_d;
  logic [63:0] inst_pc_d;
  logic        fault_d;
  logic        arvalid_q, rready_q, inst_valid_q;
  logic [31:0] rd_word;
  logic        ar_fire, r_fire, out_fire;

  generate
    if (BUS_DW == 64) begin : g_dw64
      assign araddr  = {pc[31:3], 3'b000};
      assign rd_word = pc[2] ? rdata[63:32] : rdata[31:0];
    end else begin : g_dw32
      assign araddr  = pc[31:0];
      assign rd_word = rdata[31:0];
    end
  endgenerate

  // Handshake outputs are registered; reset masks them so nothing completes during it.
  assign arvalid    = arvalid_q & ~rst;
  assign rready     = rready_q & ~rst;
  assign inst_valid = inst_valid_q & ~rst;

  assign ar_fire  = arvalid & arready;
  assign r_fire   = rready & rvalid;
  assign out_fire = inst_valid & inst_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_AR;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_d       = pc;
    inst_d     = inst;
    inst_pc_d  = inst_pc;
    fault_d    = inst_fault;
    case (state)
      S_AR: begin
        if (pc_misaligned(pc[1:0])) begin
          next_state = S_OUT;
          inst_d     = INST_EBREAK;
          inst_pc_d  = pc;
          fault_d    = 1'b1;
        end else if (ar_fire) begin
          next_state = S_R;
        end
      end
      S_R: begin
        if (r_fire) begin
          next_state = S_OUT;
          inst_pc_d  = pc;
          if (rresp != RESP_OKAY) begin
            inst_d  = INST_EBREAK;
            fault_d = 1'b1;
          end else begin
            inst_d  = rd_word;
            fault_d = 1'b0;
          end
        end
      end
      S_OUT: begin
        if (out_fire) next_state = S_NPC;
      end
      S_NPC: begin
        if (npc_valid) begin
          next_state = S_AR;
          pc_d       = npc;
          fault_d    = 1'b0;
        end
      end
      default: next_state = S_AR;
    endcase
  end

  // Handshake flags are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      inst         <= '0;
      inst_pc      <= '0;
      inst_fault   <= 1'b0;
      arvalid_q    <= ~pc_misaligned(RESET_PC[1:0]);
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      pc           <= pc_d;
      inst         <= inst_d;
      inst_pc      <= inst_pc_d;
      inst_fault   <= fault_d;
      arvalid_q    <= (next_state == S_AR) && !pc_misaligned(pc_d[1:0]);
      rready_q     <= (next_state == S_R);
      inst_valid_q <= (next_state == S_OUT);
    end
  end

`ifdef IFU_PERF_EN
  ifu_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .fetch_evt      (out_fire),
    .stall_evt      ((state == S_AR) || (state == S_R)),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

  // The next PC must only arrive while the unit is waiting for it.
  npc_only_in_wait: assert property (@(posedge clk) disable iff (rst) npc_valid |-> (state == S_NPC));

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: randomized fetches against an arithmetic reference model.
module tb_inst_fetch;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [63:0] npc = '0;
  logic        npc_valid = 1'b0;
`ifdef IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  int          check_cnt = 0;
  int          pass_cnt = 0;
  int          hs_since_reset = 0;
  logic [63:0] cur_pc;
  logic [31:0] ar_q[$];
  exp_t        out_q[$];

  inst_fetch #(.RESET_PC(RST_PC), .BUS_DW(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_fault (inst_fault),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .npc        (npc),
    .npc_valid  (npc_valid)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Inputs change 2 time units after the rising edge; the monitor samples at the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: expected fetch result derived from the PC and bus response.
  function automatic exp_t model(input logic [63:0] pc, input logic [63:0] rd, input logic [1:0] resp);
    exp_t e;
    e.pc = pc;
    if ((pc % 4) != 0 || resp != 2'b00) begin
      e.inst  = EBREAK;
      e.fault = 1'b1;
    end else begin
      e.inst  = ((pc % 8) == 4) ? 32'(rd >> 32) : 32'(rd & 64'hFFFF_FFFF);
      e.fault = 1'b0;
    end
    return e;
  endfunction

  task automatic arPhase(input int ar_d);
    int n;
    ar_q.push_back(32'(cur_pc - (cur_pc % 8)));
    arready = 1'b0;
    repeat (ar_d) tick();
    arready = 1'b1;
    n = 0;
    while (!arvalid && n < 64) begin tick(); n++; end
    if (!arvalid) checkOutput("ar_wait", {63'd0, arvalid}, 64'd1);
    tick();
    arready = 1'b0;
  endtask

  task automatic applyStimulus(input logic [63:0] rd, input logic [1:0] resp,
                               input int ar_d, input int r_d, input int out_d);
    int n;
    out_q.push_back(model(cur_pc, rd, resp));
    if ((cur_pc % 4) == 0) begin
      arPhase(ar_d);
      repeat (r_d) tick();
      rvalid = 1'b1;
      rdata  = rd;
      rresp  = resp;
      n = 0;
      while (!rready && n < 64) begin tick(); n++; end
      if (!rready) checkOutput("r_wait", {63'd0, rready}, 64'd1);
      tick();
      rvalid = 1'b0;
      rdata  = {$urandom, $urandom};
      rresp  = 2'b00;
    end
    inst_ready = 1'b0;
    repeat (out_d) tick();
    inst_ready = 1'b1;
    n = 0;
    while (!inst_valid && n < 64) begin tick(); n++; end
    if (!inst_valid) checkOutput("out_wait", {63'd0, inst_valid}, 64'd1);
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic sendNpc(input logic [63:0] p, input int idle);
    repeat (idle) tick();
    npc       = p;
    npc_valid = 1'b1;
    tick();
    npc_valid = 1'b0;
    cur_pc    = p;
  endtask

  // Monitor: every presented output is compared to the head of its queue; handshakes pop.
  always @(negedge clk) begin
    if (!rst) begin
      if (arvalid) begin
        if (ar_q.size() == 0) checkOutput("unexpected_arvalid", {63'd0, arvalid}, 64'd0);
        else begin
          checkOutput("araddr", {32'd0, araddr}, {32'd0, ar_q[0]});
          if (arready) void'(ar_q.pop_front());
        end
      end
      if (inst_valid) begin
        if (out_q.size() == 0) checkOutput("unexpected_inst_valid", {63'd0, inst_valid}, 64'd0);
        else begin
          checkOutput("inst", {32'd0, inst}, {32'd0, out_q[0].inst});
          checkOutput("inst_pc", inst_pc, out_q[0].pc);
          checkOutput("inst_fault", {63'd0, inst_fault}, {63'd0, out_q[0].fault});
          if (inst_ready) begin
            void'(out_q.pop_front());
            hs_since_reset++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic resetChecks(input string tag);
    checkOutput({tag, "_arvalid"}, {63'd0, arvalid}, 64'd0);
    checkOutput({tag, "_rready"}, {63'd0, rready}, 64'd0);
    checkOutput({tag, "_inst_valid"}, {63'd0, inst_valid}, 64'd0);
    checkOutput({tag, "_inst"}, {32'd0, inst}, 64'd0);
    checkOutput({tag, "_inst_pc"}, inst_pc, 64'd0);
    checkOutput({tag, "_inst_fault"}, {63'd0, inst_fault}, 64'd0);
`ifdef IFU_PERF_EN
    checkOutput({tag, "_perf_fetch"}, perf_fetch_cnt, 64'd0);
    checkOutput({tag, "_perf_stall"}, perf_stall_cnt, 64'd0);
`endif
  endtask

  initial begin
    logic [63:0] p;
    logic [63:0] rd;
    logic [1:0]  resp;

    repeat (3) tick();
    resetChecks("reset");
    rst = 1'b0;
    hs_since_reset = 0;
    #1;
    checkOutput("post_reset_arvalid", {63'd0, arvalid}, 64'd1);
    checkOutput("post_reset_araddr", {32'd0, araddr}, 64'h8000_0000);
    cur_pc = RST_PC;

    applyStimulus(64'h0000_0013_0010_0093, 2'b00, 0, 0, 0);
    sendNpc(64'h8000_0004, 0);
    applyStimulus(64'h0000_0013_0010_0093, 2'b00, 0, 0, 0);
    sendNpc(64'h8000_0010, 1);
    applyStimulus({$urandom, $urandom}, 2'b00, 5, 1, 4);
    sendNpc(64'h8000_0006, 0);
    applyStimulus({$urandom, $urandom}, 2'b00, 0, 0, 2);
    sendNpc(64'h8000_0008, 2);
    applyStimulus({$urandom, $urandom}, 2'b10, 0, 0, 0);
    sendNpc(64'h8000_000C, 0);
    applyStimulus({$urandom, $urandom}, 2'b00, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      p = {$urandom, $urandom};
      p[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rd   = {$urandom, $urandom};
      resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      sendNpc(p, $urandom_range(0, 2));
      applyStimulus(rd, resp, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Abort a fetch in the read phase with the response arriving alongside reset.
    sendNpc(64'h8000_1234_5678_9A10, 0);
    arPhase(0);
    rvalid = 1'b1;
    rdata  = 64'hDEAD_BEEF_CAFE_F00D;
    rresp  = 2'b00;
    rst    = 1'b1;
    tick();
    resetChecks("abort");
    rst    = 1'b0;
    rvalid = 1'b0;
    hs_since_reset = 0;
    #1;
    checkOutput("abort_arvalid", {63'd0, arvalid}, 64'd1);
    checkOutput("abort_araddr", {32'd0, araddr}, 64'h8000_0000);
    cur_pc = RST_PC;
    applyStimulus(64'h1111_2222_0000_0113, 2'b00, 0, 0, 0);
    sendNpc(64'h8000_0004, 0);
    applyStimulus(64'h1111_2222_0000_0113, 2'b00, 1, 1, 1);
    repeat (3) tick();

    checkOutput("ar_queue_drained", 64'(ar_q.size()), 64'd0);
    checkOutput("out_queue_drained", 64'(out_q.size()), 64'd0);
`ifdef IFU_PERF_EN
    checkOutput("perf_fetch_total", perf_fetch_cnt, 64'(hs_since_reset));
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
